multdiv_unit: RTL and testbench
===============================

Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit; its result is written into the 32x32 register file through data_writeReg.
- It sits in the execute stage, beside the ALU.
- The pipeline issues a one-cycle start pulse, then stalls until data_resultRDY.
- On data_resultRDY the writeback logic writes data_result into the register file, or writes the exception status into the status register when data_exception is set.

Parameters:
- DATA_WIDTH, 32, operand and result width. Iteration count equals DATA_WIDTH. Only 32 is required to be verified.

Ports:
- clock  input  1  system clock; all state updates on its rising edge
- ctrl_reset  input  1  asynchronous, active-high reset
- ctrl_MULT  input  1  single-cycle start pulse for a multiply
- ctrl_DIV  input  1  single-cycle start pulse for a divide
- data_operandA  input  32  multiplicand or dividend, two's complement
- data_operandB  input  32  multiplier or divisor, two's complement
- data_result  output  32  product low word, or quotient
- data_exception  output  1  overflow or divide-by-zero flag, valid with data_resultRDY
- data_resultRDY  output  1  one-cycle pulse: result and exception valid
- busy  output  1  high while an operation is in progress

Behaviour:
- Interface (already decided): one clock, named clock. Reset is ctrl_reset, asynchronous and active-high.
- Reset:
  - Asserting ctrl_reset immediately forces state=IDLE, counter=0 and all datapath registers to 0.
  - Outputs under reset: data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Reset mid-operation discards the operation; no data_resultRDY is produced.
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- Start:
  - A start is sampled on any rising edge (edge S) where ctrl_MULT or ctrl_DIV is high, in any state.
  - The start latches both operands and the op type, clears the counter, and enters MUL_RUN or DIV_RUN.
  - If both are high, MULT wins.
  - A start while busy aborts the current operation and restarts with the new operands. The aborted operation produces no data_resultRDY.
- busy: high from after edge S until after edge S+33, when data_resultRDY rises.
- Iteration: counter runs 0..31 over edges S+1..S+32, one iteration per edge. After edge S+32 the state is DONE.
- Completion:
  - On edge S+33: data_result and data_exception are registered, data_resultRDY goes high, and the state returns to IDLE.
  - data_resultRDY falls after edge S+34 unless another start intervenes.
  - Fixed latency: 33 cycles from the start edge to data_resultRDY, for every operand value, including divide-by-zero.
- Hold: data_result and data_exception hold their values after data_resultRDY until the next completion or reset. A new start does not clear them.
- Multiply:
  - Radix-2 shift-add on operand magnitudes into a 64-bit accumulator, then conditional negate when the operand signs differ.
  - data_result = low 32 bits of the signed 64-bit product.
  - data_exception=1 when the 64-bit product is outside -2^31..2^31-1, i.e. the upper 33 bits are not all equal.
  - A zero operand never raises an exception.
- Divide:
  - Restoring division on magnitudes, 1 quotient bit per iteration.
  - Quotient is negated when the operand signs differ; rounding truncates toward zero. The remainder is discarded.
  - Divisor 0: data_result=0, data_exception=1.
  - 0x80000000 / 0xFFFFFFFF: data_result=0, data_exception=1 (quotient not representable).
  - Magnitude of 0x80000000 is computed as 33-bit unsigned 2^31 and must not overflow internally.
- Start pulses held high for more than one cycle restart the operation every cycle. The issuing pipeline guarantees single-cycle pulses.
- Operand inputs are ignored except on a start edge; they may change freely while busy.

Test Plan:
- Multiply, positive operands: ctrl_MULT pulse with A=7, B=6. At edge S+33: data_resultRDY=1 for exactly 1 cycle, data_result=42, data_exception=0, busy=0 afterwards.
- Multiply, mixed sign and overflow:
  - A=-3 (0xFFFFFFFD), B=5 gives result 0xFFFFFFF1, exception=0.
  - Then A=0x00010000, B=0x00010000 gives result 0x00000000, exception=1.
  - Then A=0x80000000, B=1 gives result 0x80000000, exception=0.
- Divide, signed truncation:
  - 100/7 gives 14, exception=0.
  - -100/7 gives -14 (0xFFFFFFF2).
  - 7/-100 gives 0.
  - 0x80000000/2 gives 0xC0000000.
- Divide exceptions:
  - 55/0 gives result 0, exception=1, latency still 33.
  - 0x80000000/0xFFFFFFFF gives result 0, exception=1.
- Restart and priority:
  - A MULT 3*4 restarted at cycle 10 by DIV 20/5 yields a single data_resultRDY at 33 cycles after the DIV edge, with result 4. No pulse appears for the aborted multiply.
  - Simultaneous ctrl_MULT and ctrl_DIV with A=9, B=3 gives 27.
- Reset mid-operation:
  - Raise ctrl_reset between clock edges at cycle 15 of a multiply. Outputs immediately read result 0, exception 0, resultRDY 0, busy 0.
  - No data_resultRDY follows.
  - The next MULT 2*2 after reset release returns 4 with the normal 33-cycle latency.

Source files
------------

// File: rtl/multdiv_unit_if.sv
// Start/operand/result bundle between the issuing pipeline and multdiv_unit.
//   master : pipeline side, drives the start pulses and operands, observes results
//   slave  : multdiv_unit side
//   ctrl_MULT, ctrl_DIV  single-cycle start pulses (MULT wins when both high)
//   data_operandA/B      two's-complement operands, sampled on a start edge only
//   data_result          product low word or quotient, held until next completion
//   data_exception       overflow / divide-by-zero, valid with data_resultRDY
//   data_resultRDY       one-cycle completion pulse
//   busy                 high while an operation is in flight
interface multdiv_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  ctrl_MULT;
    logic                  ctrl_DIV;
    logic [DATA_WIDTH-1:0] data_operandA;
    logic [DATA_WIDTH-1:0] data_operandB;
    logic [DATA_WIDTH-1:0] data_result;
    logic                  data_exception;
    logic                  data_resultRDY;
    logic                  busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply / divide unit with a fixed DATA_WIDTH+1 cycle latency.
//   clock       system clock, rising edge
//   ctrl_reset  asynchronous active-high reset, discards any operation in flight
//   bus         multdiv_unit_if slave: start pulses, operands, result/exception/ready/busy
// Multiply: radix-2 shift-add on magnitudes, negate when signs differ.
// Divide: restoring division on magnitudes, quotient truncated toward zero.
module multdiv_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    multdiv_unit_if.slave bus
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

    state_t        state, nextState;
    logic [CW-1:0] counter;
    logic [W:0]    accHi;      // multiply: running high word; divide: partial remainder
    logic [W-1:0]  accLo;      // multiply: multiplier shifting out; divide: dividend -> quotient
    logic [W:0]    opMag;      // multiply: multiplicand magnitude; divide: divisor magnitude
    logic          negRes;
    logic          opDiv;
    logic [W-1:0]  resultQ;
    logic          exceptionQ;
    logic          rdyQ;
    logic          busyQ;

    logic          start;
    logic [W:0]    magA, magB;
    logic [W:0]    mulSum;
    logic [W:0]    divShift;
    logic          divGe;
    logic [2*W-1:0] prodMag, prodSigned;
    logic          mulOvf;
    logic [W-1:0]  quotSigned;
    logic          divOvf, divZero;

    // Sign-extend before negating so the most negative value yields +2^(W-1).
    function automatic logic [W:0] magnitude(input logic [W-1:0] x);
        logic [W:0] xs;
        xs = {x[W-1], x};
        return x[W-1] ? (~xs + (W+1)'(1)) : xs;
    endfunction

    assign start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign magA  = magnitude(bus.data_operandA);
    assign magB  = magnitude(bus.data_operandB);

    // One iteration of each algorithm.
    assign mulSum   = {1'b0, accHi[W-1:0]} + (accLo[0] ? opMag : '0);
    assign divShift = {accHi[W-1:0], accLo[W-1]};
    assign divGe    = divShift >= opMag;

    // Completion: sign fix-up and exception detection.
    assign prodMag    = {accHi[W-1:0], accLo};
    assign prodSigned = negRes ? (~prodMag + (2*W)'(1)) : prodMag;
    assign mulOvf     = !((&prodSigned[2*W-1:W-1]) || !(|prodSigned[2*W-1:W-1]));
    assign quotSigned = negRes ? (~accLo + W'(1)) : accLo;
    assign divZero    = (opMag == '0);
    assign divOvf     = !negRes && accLo[W-1];

    // State register.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) state <= IDLE;
        else            state <= nextState;
    end

    // Next state: a start overrides everything, including an operation in flight.
    always_comb begin
        nextState = state;
        if (start) begin
            nextState = bus.ctrl_MULT ? MUL_RUN : DIV_RUN;
        end else begin
            case (state)
                MUL_RUN, DIV_RUN: if (counter == CW'(W-1)) nextState = DONE;
                DONE:             nextState = IDLE;
                default:          nextState = state;
            endcase
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            counter    <= '0;
            accHi      <= '0;
            accLo      <= '0;
            opMag      <= '0;
            negRes     <= 1'b0;
            opDiv      <= 1'b0;
            resultQ    <= '0;
            exceptionQ <= 1'b0;
            rdyQ       <= 1'b0;
            busyQ      <= 1'b0;
        end else begin
            rdyQ  <= 1'b0;
            busyQ <= (nextState != IDLE);
            if (start) begin
                counter <= '0;
                accHi   <= '0;
                opDiv   <= !bus.ctrl_MULT;
                negRes  <= bus.data_operandA[W-1] ^ bus.data_operandB[W-1];
                if (bus.ctrl_MULT) begin
                    opMag <= magA;
                    accLo <= magB[W-1:0];
                end else begin
                    opMag <= magB;
                    accLo <= magA[W-1:0];
                end
            end else begin
                case (state)
                    MUL_RUN: begin
                        accHi   <= {1'b0, mulSum[W:1]};
                        accLo   <= {mulSum[0], accLo[W-1:1]};
                        counter <= counter + CW'(1);
                    end
                    DIV_RUN: begin
                        accHi   <= divGe ? (divShift - opMag) : divShift;
                        accLo   <= {accLo[W-2:0], divGe};
                        counter <= counter + CW'(1);
                    end
                    DONE: begin
                        rdyQ <= 1'b1;
                        if (!opDiv) begin
                            resultQ    <= prodSigned[W-1:0];
                            exceptionQ <= mulOvf;
                        end else if (divZero || divOvf) begin
                            resultQ    <= '0;
                            exceptionQ <= 1'b1;
                        end else begin
                            resultQ    <= quotSigned;
                            exceptionQ <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.data_result    = resultQ;
    assign bus.data_exception = exceptionQ;
    assign bus.data_resultRDY = rdyQ;
    assign bus.busy           = busyQ;
endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed vector table plus restart and reset sequences.
module tb_multdiv_unit;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    multdiv_unit_if #(.DATA_WIDTH(32)) mdIf ();

    multdiv_unit #(.DATA_WIDTH(32)) dut (
        .clock      (clk),
        .ctrl_reset (rst),
        .bus        (mdIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        isMul;
        logic        isDiv;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expRes;
        logic        expExc;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Pulse the start lines for exactly one rising edge; returns at the negedge after it.
    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mdIf.ctrl_MULT     = m;
        mdIf.ctrl_DIV      = d;
        mdIf.data_operandA = a;
        mdIf.data_operandB = b;
        @(negedge clk);
        mdIf.ctrl_MULT     = 1'b0;
        mdIf.ctrl_DIV      = 1'b0;
        mdIf.data_operandA = $urandom;
        mdIf.data_operandB = $urandom;
    endtask

    // Count edges after the start edge until data_resultRDY; 0 means it never came.
    task automatic waitRdy(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (mdIf.data_resultRDY === 1'b1) begin
                lat = k - 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic runVec(input string name, input vec_t v);
        int lat;
        issue(v.isMul, v.isDiv, v.a, v.b);
        check({name, " busy"}, 32'(mdIf.busy), 32'd1);
        waitRdy(lat);
        check({name, " latency"}, 32'(lat), 32'd33);
        check({name, " result"}, mdIf.data_result, v.expRes);
        check({name, " exception"}, 32'(mdIf.data_exception), 32'(v.expExc));
        check({name, " busy done"}, 32'(mdIf.busy), 32'd0);
        @(negedge clk);
        check({name, " rdy fall"}, 32'(mdIf.data_resultRDY), 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        checks   = 0;
        failures = 0;
        mdIf.ctrl_MULT     = 1'b0;
        mdIf.ctrl_DIV      = 1'b0;
        mdIf.data_operandA = '0;
        mdIf.data_operandB = '0;
        rst = 1'b1;

        vecs[0]  = '{1'b1, 1'b0, 32'd7,        32'd6,        32'd42,       1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'd0,        32'hFFFFFFFB, 32'd0,        1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'd100,      32'd7,        32'd14,       1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'd7,        32'hFFFFFF9C, 32'd0,        1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'h80000000, 32'd2,        32'hC0000000, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'd55,       32'd0,        32'd0,        1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1};
        vecs[13] = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 32'd9,        32'd3,        32'd27,       1'b0};

        #12;
        check("reset result", mdIf.data_result, 32'd0);
        check("reset exception", 32'(mdIf.data_exception), 32'd0);
        check("reset rdy", 32'(mdIf.data_resultRDY), 32'd0);
        check("reset busy", 32'(mdIf.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) runVec($sformatf("vec%0d", i), vecs[i]);

        // Restart: MULT 3*4 aborted 10 edges in by DIV 20/5.
        issue(1'b1, 1'b0, 32'd3, 32'd4);
        check("restart hold result", mdIf.data_result, 32'd27);
        pulses = 0;
        repeat (9) begin
            @(negedge clk);
            if (mdIf.data_resultRDY === 1'b1) pulses++;
        end
        issue(1'b0, 1'b1, 32'd20, 32'd5);
        waitRdy(lat);
        check("restart latency", 32'(lat), 32'd33);
        check("restart result", mdIf.data_result, 32'd4);
        repeat (40) begin
            @(negedge clk);
            if (mdIf.data_resultRDY === 1'b1) pulses++;
        end
        check("restart extra pulses", 32'(pulses), 32'd0);

        // Reset between edges in the middle of a multiply.
        issue(1'b1, 1'b0, 32'd5, 32'd7);
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst result", mdIf.data_result, 32'd0);
        check("midrst exception", 32'(mdIf.data_exception), 32'd0);
        check("midrst rdy", 32'(mdIf.data_resultRDY), 32'd0);
        check("midrst busy", 32'(mdIf.busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (mdIf.data_resultRDY === 1'b1) pulses++;
        end
        check("midrst no rdy", 32'(pulses), 32'd0);
        runVec("postrst", '{1'b1, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
